// File: rtl/comparador_secuencial_ctrl_if.sv
// Request/result bundle between a requesting unit and the sequential
// magnitude comparator controller.
interface comparador_secuencial_ctrl_if #(
  parameter int WIDTH = 12,
  parameter int IDX_W = 2
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [IDX_W-1:0] slice_idx;

  modport master (
    output start, A, B,
    input  busy, done, gt, lt, eq, slice_idx
  );

  modport slave (
    input  start, A, B,
    output busy, done, gt, lt, eq, slice_idx
  );
endinterface

// File: rtl/comparador_secuencial_ctrl.sv
// MSB-first iterative magnitude comparator: one SLICE-bit slice per clock,
// with the f/g decision carried in registers and a start/busy/done handshake.
module comparador_secuencial_ctrl #(
  parameter int WIDTH      = 12,
  parameter int SLICE      = 3,
  parameter int EARLY_EXIT = 1
) (
  input logic                       clk,
  input logic                       rst_n,
  comparador_secuencial_ctrl_if.slave bus
);
  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NSLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [NSLICES-1:0][SLICE-1:0] a_r, b_r;
  logic [IDX_W-1:0]              idx;
  logic                          f, g;
  logic                          f_new, g_new;
  logic                          last_slice;
  logic                          gt_r, lt_r, eq_r;
  logic                          accept;

  assign accept = (state == IDLE) && bus.start;

  // State register
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers see the pre-edge values of each other, whatever block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Slice decision: once f or g is set it is held, so later slices cannot override.
  // NOTE: each combinational output gets a default before any branch; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    f_new = f;
    g_new = g;
    if (!(f || g)) begin
      f_new = a_r[idx] > b_r[idx];
      g_new = a_r[idx] < b_r[idx];
    end
    last_slice = (idx == '0) || ((EARLY_EXIT != 0) && (f_new || g_new));
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state only
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // Decision state, slice index and results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f    <= 1'b0;
      g    <= 1'b0;
      idx  <= '0;
      gt_r <= 1'b0;
      lt_r <= 1'b0;
      eq_r <= 1'b0;
    end else begin
      if (accept) begin
        f    <= 1'b0;
        g    <= 1'b0;
        idx  <= TOP_IDX;
        gt_r <= 1'b0;
        lt_r <= 1'b0;
        eq_r <= 1'b0;
      end else if (state == RUN) begin
        f   <= f_new;
        g   <= g_new;
        idx <= idx - 1'b1;
        if (last_slice) begin
          gt_r <= f_new;
          lt_r <= g_new;
          eq_r <= ~(f_new | g_new);
        end
      end
    end
  end

  // Operand capture
  // NOTE: the operand registers are pure data, only read in RUN after a
  // capture, so they are deliberately left without reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= bus.A;
      b_r <= bus.B;
    end
  end

  assign bus.gt        = gt_r;
  assign bus.lt        = lt_r;
  assign bus.eq        = eq_r;
  assign bus.slice_idx = idx;
endmodule

// File: tb/tb_comparador_secuencial_ctrl.sv
// Bench: two controllers (EARLY_EXIT=0 and 1) fed with the same requests and
// checked against an arithmetic reference of the comparison and its latency.
module tb_comparador_secuencial_ctrl;
  localparam int WIDTH   = 12;
  localparam int SLICE   = 3;
  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDX_W   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Index 0: EARLY_EXIT=0, index 1: EARLY_EXIT=1
  comparador_secuencial_ctrl_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) if_e0 ();
  comparador_secuencial_ctrl_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) if_e1 ();

  assign if_e0.start = start;
  assign if_e0.A     = a_in;
  assign if_e0.B     = b_in;
  assign if_e1.start = start;
  assign if_e1.A     = a_in;
  assign if_e1.B     = b_in;

  comparador_secuencial_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE), .EARLY_EXIT(0)) dut_e0 (
    .clk(clk), .rst_n(rst_n), .bus(if_e0.slave));
  comparador_secuencial_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE), .EARLY_EXIT(1)) dut_e1 (
    .clk(clk), .rst_n(rst_n), .bus(if_e1.slave));

  logic [1:0] busy_v, done_v, gt_v, lt_v, eq_v;
  logic [IDX_W-1:0] idx_v [2];
  assign busy_v = {if_e1.busy, if_e0.busy};
  assign done_v = {if_e1.done, if_e0.done};
  assign gt_v   = {if_e1.gt,   if_e0.gt};
  assign lt_v   = {if_e1.lt,   if_e0.lt};
  assign eq_v   = {if_e1.eq,   if_e0.eq};
  assign idx_v[0] = if_e0.slice_idx;
  assign idx_v[1] = if_e1.slice_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slices processed: all of them without early exit or when equal, otherwise
  // up to and including the slice holding the highest differing bit.
  function automatic int ref_n(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int ee);
    logic [WIDTH-1:0] d;
    d = a ^ b;
    if (ee == 0 || d == '0) return NSLICES;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (d[i]) return NSLICES - i / SLICE;
    return NSLICES;
  endfunction

  task automatic check_idle_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_busy%0d", tag, i), 32'(busy_v[i]), 0);
      check($sformatf("%s_done%0d", tag, i), 32'(done_v[i]), 0);
      check($sformatf("%s_res%0d", tag, i), {29'd0, gt_v[i], lt_v[i], eq_v[i]}, 0);
      check($sformatf("%s_idx%0d", tag, i), 32'(idx_v[i]), 0);
    end
  endtask

  // One request; optional second start pulse while the first is in flight.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit inject, input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2);
    int n [2];
    int dcnt [2];
    int dcyc [2];
    logic [2:0] res [2];
    logic busy_after [2];
    logic [2:0] exp_res;
    exp_res = {a > b, a < b, a == b};
    for (int i = 0; i < 2; i++) begin
      n[i] = ref_n(a, b, i);
      dcnt[i] = 0;
      dcyc[i] = -1;
      res[i] = 3'b000;
      busy_after[i] = 1'b1;
    end
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_acc_busy%0d", tag, i), 32'(busy_v[i]), 1);
      check($sformatf("%s_acc_clr%0d", tag, i), {29'd0, gt_v[i], lt_v[i], eq_v[i]}, 0);
      check($sformatf("%s_acc_idx%0d", tag, i), 32'(idx_v[i]), NSLICES - 1);
    end
    for (int c = 1; c <= NSLICES + 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (done_v[i]) begin
          dcnt[i]++;
          dcyc[i] = c;
          res[i] = {gt_v[i], lt_v[i], eq_v[i]};
        end
        if (c == n[i] + 1) busy_after[i] = busy_v[i];
      end
      if (inject && c == 1) begin
        start = 1'b1; a_in = a2; b_in = b2;
      end else if (c == 2) begin
        start = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_ndone%0d", tag, i), 32'(dcnt[i]), 1);
      check($sformatf("%s_lat%0d", tag, i), 32'(dcyc[i]), 32'(n[i]));
      check($sformatf("%s_res%0d", tag, i), 32'(res[i]), 32'(exp_res));
      check($sformatf("%s_busyoff%0d", tag, i), 32'(busy_after[i]), 0);
      check($sformatf("%s_hold%0d", tag, i), {29'd0, gt_v[i], lt_v[i], eq_v[i]}, 32'(exp_res));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ndone;
    int q_obs [2][$];
    int q_exp [2][$];
    logic [WIDTH-1:0] ra, rb, ra2, rb2;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    run_op("eq5252", 12'o5252, 12'o5252, 1'b0, '0, '0);
    run_op("gt7000", 12'o7000, 12'o6777, 1'b0, '0, '0);
    run_op("lt1234", 12'o1234, 12'o1235, 1'b0, '0, '0);
    run_op("lt0100", 12'o0000, 12'o0100, 1'b0, '0, '0);
    run_op("ignore", 12'o0001, 12'o0000, 1'b1, 12'o0000, 12'o7777);

    // Reset one edge after acceptance
    @(negedge clk);
    start = 1'b1; a_in = 12'o4000; b_in = 12'o3000;
    @(negedge clk);
    start = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check_idle_zero("midrst");
    rst_n = 1'b1;
    ndone = 0;
    repeat (NSLICES + 4) begin
      @(negedge clk);
      ndone += int'(done_v[0]) + int'(done_v[1]);
    end
    check("midrst_nodone", 32'(ndone), 0);
    run_op("after_rst", 12'o2222, 12'o2223, 1'b0, '0, '0);

    // start held high: back-to-back operations every n+2 cycles
    @(negedge clk);
    start = 1'b1; a_in = 12'o0300; b_in = 12'o0200;
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (done_v[i]) begin
          q_obs[i].push_back(c);
          check($sformatf("b2b_gt%0d_c%0d", i, c), {29'd0, gt_v[i], lt_v[i], eq_v[i]}, 32'b100);
        end
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int n;
      n = ref_n(12'o0300, 12'o0200, i);
      for (int c = n; c <= 20; c += n + 2) q_exp[i].push_back(c);
      check($sformatf("b2b_count%0d", i), 32'(q_obs[i].size()), 32'(q_exp[i].size()));
      for (int k = 0; k < q_exp[i].size() && k < q_obs[i].size(); k++)
        check($sformatf("b2b_cyc%0d_%0d", i, k), 32'(q_obs[i][k]), 32'(q_exp[i][k]));
    end
    repeat (NSLICES + 4) @(negedge clk);

    // Randomized requests, biased toward equal and near-equal operands
    for (int t = 0; t < 24; t++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = WIDTH'($urandom);
        1:       rb = ra;
        default: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      endcase
      ra2 = WIDTH'($urandom);
      rb2 = WIDTH'($urandom);
      run_op($sformatf("rnd%0d", t), ra, rb, 1'($urandom_range(0, 1)), ra2, rb2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/comparador_secuencial_ctrl.md
# comparador_secuencial_ctrl

Sequential controller that drives a left-to-right (MSB-first) iterative magnitude comparison of two WIDTH-bit operands. It evaluates one SLICE-bit slice per clock, applying the `celda_inicial` f/g cell rule on the first slice and the propagate-or-decide rule on every later slice. Decision state is carried in registers instead of a combinational cell chain. It sits between a requesting unit and the comparator datapath, and provides a start/busy/done handshake with registered gt/lt/eq results.

## Interface
- WIDTH, 12: operand width in bits; must be a multiple of SLICE.
- SLICE, 3: bits compared per cycle; one slice matches the celda_inicial input width.
- EARLY_EXIT, 1: 1 = finish as soon as f or g is set; 0 = always process all NSLICES = WIDTH/SLICE slices.
- clk  input  1  single clock; all logic updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured when start is accepted.
- B  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- gt  output  1  A > B.
- lt  output  1  A < B.
- eq  output  1  A == B.
- slice_idx  output  clog2(NSLICES) (minimum 1)  index of the slice being processed (debug only).

## Operation
- States are IDLE, RUN and DONE. The reset state is IDLE.
- **IDLE, start=1:**
  - Capture A into a_r and B into b_r.
  - Clear f and g to 0.
  - Set idx to NSLICES-1.
  - Clear gt, lt and eq.
  - Go to RUN.
- **IDLE, start=0:** stay in IDLE. gt/lt/eq keep their last values.
- **RUN, each edge:** take the slice pair a_s = a_r[idx*SLICE +: SLICE] and b_s = b_r[idx*SLICE +: SLICE].
  - If f|g is already set, hold f and g.
  - Otherwise set f = (a_s > b_s) and g = (a_s < b_s), compared as unsigned.
  - Decrement idx.
- **RUN exit:** go to DONE when idx == 0, or when EARLY_EXIT=1 and the updated f|g is 1. On that same edge:
  - gt <= f_new
  - lt <= g_new
  - eq <= ~(f_new | g_new)
- **DONE:**
  - done=1 for exactly one cycle, then go to IDLE.
  - gt/lt/eq hold until the next accepted start.
- **Invariants:**
  - f and g are never both 1.
  - Exactly one of gt/lt/eq is 1 after any completed operation.
- start in RUN or DONE is ignored; it is not queued. The operands of an ignored request are not captured.
- A and B may change freely after acceptance; only a_r and b_r are used.
- **Reset:** rst_n=0 at an edge, including mid-RUN, does the following. The operation is abandoned and produces no done.
  - State goes to IDLE.
  - busy=0, done=0, gt=0, lt=0, eq=0.
  - slice_idx=0, f=g=0.

## Timing
- start is accepted at edge k. RUN occupies edges k+1 .. k+n, where n is the number of slices processed.
- n = NSLICES when EARLY_EXIT=0 or the operands are equal. Otherwise n = (index from MSB of the first differing slice) + 1.
- done is high in the cycle between edges k+n and k+n+1.
- busy rises after edge k and falls after edge k+n+1.
- A new start is accepted no earlier than edge k+n+2. This gives a minimum issue interval of n+2 cycles.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Test plan
All scenarios use WIDTH=12, SLICE=3.
- Reset, then A=B=12'o5252, start pulse (EARLY_EXIT=1) -> 4 RUN cycles; done after edge 4; eq=1, gt=0, lt=0.
- A=12'o7000, B=12'o6777: with EARLY_EXIT=1 -> done after edge 1, gt=1; with EARLY_EXIT=0 -> done after edge 4, gt=1 (later slices do not override).
- A=12'o1234, B=12'o1235 -> decided on the last slice; done after edge 4; lt=1. A=12'o0000, B=12'o0100 -> done after edge 2 (EARLY_EXIT=1); lt=1.
- start A=12'o0001, B=12'o0000; one cycle later, pulse start with A=12'o0000, B=12'o7777 while busy -> second request ignored; result gt=1; exactly one done pulse.
- Start, then drop rst_n low at the edge after acceptance -> next cycle busy=0, done=0, gt=lt=eq=0; no done follows; a fresh start then completes normally.
- start held high continuously with A=12'o0300, B=12'o0200 -> operations complete back-to-back every n+2=4 cycles; done pulses one cycle wide; gt=1 each time.
